// File: rtl/pll_lock_pkg.sv
// ============================================================================
// Module   : pll_lock_pkg
// Purpose  : State encoding, parameter defaults and counter sizing shared by
//            the PLL lock monitor and its synchroniser.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pll_lock_pkg;

  typedef enum logic [2:0] {
    RST_PLL   = 3'd0,
    WAIT_LOCK = 3'd1,
    QUALIFY   = 3'd2,
    LOCKED    = 3'd3,
    FAIL      = 3'd4
  } pll_state_t;

  localparam int c_SYNC_STAGES_DFLT    = 2;
  localparam int c_PLL_RST_CYCLES_DFLT = 16;
  localparam int c_LOCK_TIMEOUT_DFLT   = 65536;
  localparam int c_QUALIFY_CYCLES_DFLT = 1024;
  localparam int c_MAX_RETRY_DFLT      = 7;
`ifdef PLL_LOCK_GLITCH_FILTER_EN
  localparam int c_LOSS_FILTER_DFLT    = 4;
`endif

  // Width needed to hold 0 .. n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pll_lock_sync.sv
// ============================================================================
// Module   : pll_lock_sync
// Purpose  : STAGES-deep reset-to-zero synchroniser for the raw PLL lock flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pll_lock_sync
  import pll_lock_pkg::*;
#(
  parameter int STAGES = c_SYNC_STAGES_DFLT
) (
  input  logic I_clk,
  input  logic I_rst,
  input  logic I_d,
  output logic O_q
);

  if (STAGES < 2) begin : g_chk_stages
    $error("pll_lock_sync: STAGES must be at least 2");
  end

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] r_sync;

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], I_d};
    end
  end

  assign O_q = r_sync[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/pll_lock_monitor.sv
// ============================================================================
// Module   : pll_lock_monitor
// Purpose  : Qualifies PLL lock, pulses PLL reset on timeout/loss, flags
//            terminal failure. Define PLL_LOCK_GLITCH_FILTER_EN for loss filter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pll_lock_monitor
  import pll_lock_pkg::*;
#(
  parameter int SYNC_STAGES        = c_SYNC_STAGES_DFLT,
  parameter int PLL_RST_CYCLES     = c_PLL_RST_CYCLES_DFLT,
  parameter int LOCK_TIMEOUT       = c_LOCK_TIMEOUT_DFLT,
  parameter int QUALIFY_CYCLES     = c_QUALIFY_CYCLES_DFLT,
`ifdef PLL_LOCK_GLITCH_FILTER_EN
  parameter int LOSS_FILTER_CYCLES = c_LOSS_FILTER_DFLT,
`endif
  parameter int MAX_RETRY          = c_MAX_RETRY_DFLT
) (
  input  logic       I_clk,
  input  logic       I_rst,
  input  logic       I_pll_locked,
  output logic       O_locked,
  output logic       O_pll_reset,
  output logic       O_lock_lost,
  output logic [3:0] O_retry_cnt,
  output logic [7:0] O_loss_cnt,
  output logic       O_fail
);

  localparam int c_RST_W  = cnt_width(PLL_RST_CYCLES);
  localparam int c_TMO_W  = cnt_width(LOCK_TIMEOUT);
  localparam int c_QUAL_W = cnt_width(QUALIFY_CYCLES);

  localparam logic [c_RST_W-1:0]  c_RST_LAST  = c_RST_W'(PLL_RST_CYCLES - 1);
  localparam logic [c_TMO_W-1:0]  c_TMO_LAST  = c_TMO_W'(LOCK_TIMEOUT - 1);
  localparam logic [c_QUAL_W-1:0] c_QUAL_LAST = c_QUAL_W'(QUALIFY_CYCLES - 1);
  localparam logic [3:0]          c_MAX_RETRY = 4'(MAX_RETRY);

  if (PLL_RST_CYCLES < 1 || QUALIFY_CYCLES < 1) begin : g_chk_cycles
    $error("pll_lock_monitor: PLL_RST_CYCLES and QUALIFY_CYCLES must be >= 1");
  end
  if (LOCK_TIMEOUT <= QUALIFY_CYCLES) begin : g_chk_timeout
    $error("pll_lock_monitor: LOCK_TIMEOUT must exceed QUALIFY_CYCLES");
  end
  if (MAX_RETRY < 0 || MAX_RETRY > 15) begin : g_chk_retry
    $error("pll_lock_monitor: MAX_RETRY must be within 0..15");
  end

  pll_state_t          r_state;
  pll_state_t          w_next;
  logic                w_s;
  logic                w_timeout;
  logic                w_loss;
  logic                w_loss_det;
  logic [c_RST_W-1:0]  r_rst_cnt;
  logic [c_TMO_W-1:0]  r_timer;
  logic [c_QUAL_W-1:0] r_qual_cnt;
  logic [3:0]          r_retry;
  logic [7:0]          r_loss_cnt;
  logic                r_lock_lost;

  pll_lock_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .I_clk (I_clk),
    .I_rst (I_rst),
    .I_d   (I_pll_locked),
    .O_q   (w_s)
  );

`ifdef PLL_LOCK_GLITCH_FILTER_EN
  localparam int                  c_FILT_W    = cnt_width(LOSS_FILTER_CYCLES);
  localparam logic [c_FILT_W-1:0] c_FILT_LAST = c_FILT_W'(LOSS_FILTER_CYCLES - 1);

  if (LOSS_FILTER_CYCLES < 1) begin : g_chk_filter
    $error("pll_lock_monitor: LOSS_FILTER_CYCLES must be >= 1");
  end

  logic [c_FILT_W-1:0] r_filt_cnt;

  // Run length of consecutive low samples while locked.
  always_ff @(posedge I_clk) begin
    if (I_rst || r_state != LOCKED || w_s) begin
      r_filt_cnt <= '0;
    end else begin
      r_filt_cnt <= r_filt_cnt + 1'b1;
    end
  end

  assign w_loss_det = !w_s && (r_filt_cnt == c_FILT_LAST);
`else
  assign w_loss_det = !w_s;
`endif

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_state <= RST_PLL;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_timeout   = 1'b0;
    w_loss      = 1'b0;
    O_locked    = 1'b0;
    O_pll_reset = 1'b0;
    O_fail      = 1'b0;
    case (r_state)
      RST_PLL: begin
        O_pll_reset = 1'b1;
        if (r_rst_cnt == c_RST_LAST) begin
          w_next = WAIT_LOCK;
        end
      end
      WAIT_LOCK, QUALIFY: begin
        // Timeout outranks any lock-flag movement.
        if (r_timer == c_TMO_LAST) begin
          w_timeout = 1'b1;
          w_next    = (r_retry == c_MAX_RETRY) ? FAIL : RST_PLL;
        end else if (r_state == WAIT_LOCK) begin
          if (w_s) begin
            w_next = QUALIFY;
          end
        end else if (!w_s) begin
          w_next = WAIT_LOCK;
        end else if (r_qual_cnt == c_QUAL_LAST) begin
          w_next = LOCKED;
        end
      end
      LOCKED: begin
        O_locked = 1'b1;
        if (w_loss_det) begin
          w_loss = 1'b1;
          w_next = RST_PLL;
        end
      end
      FAIL: begin
        O_fail      = 1'b1;
        O_pll_reset = 1'b1;
      end
      default: w_next = RST_PLL;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_rst_cnt   <= '0;
      r_timer     <= '0;
      r_qual_cnt  <= '0;
      r_retry     <= '0;
      r_loss_cnt  <= '0;
      r_lock_lost <= 1'b0;
    end else begin
      r_rst_cnt  <= (r_state == RST_PLL && w_next == RST_PLL) ? r_rst_cnt + 1'b1 : '0;
      r_timer    <= (r_state == WAIT_LOCK || r_state == QUALIFY) ? r_timer + 1'b1 : '0;
      r_qual_cnt <= (r_state == QUALIFY && w_s) ? r_qual_cnt + 1'b1 : '0;
      if (w_timeout && r_retry != c_MAX_RETRY) begin
        r_retry <= r_retry + 1'b1;
      end else if (r_state == QUALIFY && w_next == LOCKED) begin
        r_retry <= '0;
      end
      if (w_loss && r_loss_cnt != 8'hFF) begin
        r_loss_cnt <= r_loss_cnt + 1'b1;
      end
      r_lock_lost <= w_loss;
    end
  end

  assign O_lock_lost = r_lock_lost;
  assign O_retry_cnt = r_retry;
  assign O_loss_cnt  = r_loss_cnt;

endmodule

`default_nettype wire
